// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the two-port SDRAM arbiter.
// Port ids, SDRAM widths and the Avalon command bundle.
package sdram_port_arbiter_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;

  typedef enum logic {
    PORT_VIDEO = 1'b0,
    PORT_GAME  = 1'b1
  } port_id_e;

  typedef struct packed {
    logic [SDRAM_ADDR_W-1:0] address;
    logic                    read;
    logic                    write;
    logic [SDRAM_DATA_W-1:0] writedata;
    logic [1:0]              byteenable;
  } avl_cmd_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle for the arbiter: video port, game port,
// SDRAM controller master side and status.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 3
);
  logic [ADDR_W-1:0] v_address;
  logic              v_read;
  logic              v_waitrequest;
  logic              v_readdatavalid;

  logic [ADDR_W-1:0] g_address;
  logic              g_read;
  logic              g_write;
  logic [DATA_W-1:0] g_writedata;
  logic [1:0]        g_byteenable;
  logic              g_waitrequest;
  logic              g_readdatavalid;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [1:0]        m_byteenable;
  logic              m_waitrequest;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;

  logic [CNT_W-1:0]  outstanding;
  logic              err_stray_rdv;

  modport slave (
    input  v_address, v_read,
    output v_waitrequest, v_readdatavalid,
    input  g_address, g_read, g_write,
    input  g_writedata, g_byteenable,
    output g_waitrequest, g_readdatavalid,
    output rdata,
    output m_address, m_read, m_write,
    output m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata,
    input  m_readdatavalid,
    output outstanding, err_stray_rdv
  );

  modport master (
    output v_address, v_read,
    input  v_waitrequest, v_readdatavalid,
    output g_address, g_read, g_write,
    output g_writedata, g_byteenable,
    input  g_waitrequest, g_readdatavalid,
    input  rdata,
    input  m_address, m_read, m_write,
    input  m_writedata, m_byteenable,
    output m_waitrequest, m_readdata,
    output m_readdatavalid,
    input  outstanding, err_stray_rdv
  );

endinterface

// File: rtl/sdram_port_arbiter_tag_fifo.sv
// In-order tag FIFO remembering which port issued each read.
// Push while full is honoured only together with a pop.
module arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             din,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1))
                ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1))
                ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM Avalon master between the video fetch
// (read-only, priority) and game ports; routes read data back.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = SDRAM_ADDR_W,
  parameter int DATA_W       = SDRAM_DATA_W,
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic            Clk,
  input logic            Reset,
  sdram_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_OUT+1);
  localparam int ST_W  = $clog2(STARVE_LIMIT+1);

  logic              hold_q;
  port_id_e          grant_q;
  logic [ST_W-1:0]   starve_cnt;
  logic              v_rdv_q;
  logic              g_rdv_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic             full;
  logic             empty;
  logic             tag_dout;
  logic [CNT_W-1:0] count;

  port_id_e sel;
  logic     sel_vld;
  logic     v_elig;
  logic     g_elig;
  logic     starve_win;
  avl_cmd_t v_cmd;
  avl_cmd_t g_cmd;
  avl_cmd_t cmd;
  logic     fire;
  logic     m_rd;
  logic     m_wr;
  logic     accept;
  logic     stall;
  logic     push;
  logic     pop;
  logic     stray;
  logic     g_lost;

  assign v_elig = bus.v_read & ~full;
  assign g_elig = bus.g_write | (bus.g_read & ~full);
  assign starve_win =
    (starve_cnt == ST_W'(STARVE_LIMIT)) & g_elig;

  always_comb begin
    sel     = PORT_VIDEO;
    sel_vld = 1'b0;
    unique case (1'b1)
      hold_q: begin
        sel     = grant_q;
        sel_vld = 1'b1;
      end
      ~hold_q & starve_win: begin
        sel     = PORT_GAME;
        sel_vld = 1'b1;
      end
      ~hold_q & ~starve_win & v_elig: begin
        sel     = PORT_VIDEO;
        sel_vld = 1'b1;
      end
      ~hold_q & ~starve_win & ~v_elig & g_elig: begin
        sel     = PORT_GAME;
        sel_vld = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    v_cmd            = '0;
    v_cmd.address    = SDRAM_ADDR_W'(bus.v_address);
    v_cmd.read       = bus.v_read;
    v_cmd.byteenable = 2'b11;
    g_cmd            = '0;
    g_cmd.address    = SDRAM_ADDR_W'(bus.g_address);
    g_cmd.read       = bus.g_read;
    g_cmd.write      = bus.g_write;
    g_cmd.writedata  = SDRAM_DATA_W'(bus.g_writedata);
    g_cmd.byteenable = bus.g_byteenable;
  end

  assign cmd = (sel == PORT_GAME) ? g_cmd : v_cmd;

  // Reset forces the command strobes low regardless of inputs
  assign fire   = sel_vld & ~Reset;
  assign m_rd   = fire & cmd.read;
  assign m_wr   = fire & cmd.write;
  assign accept = (m_rd | m_wr) & ~bus.m_waitrequest;
  assign stall  = (m_rd | m_wr) & bus.m_waitrequest;
  assign push   = accept & m_rd;
  assign pop    = bus.m_readdatavalid & ~empty;
  assign stray  = bus.m_readdatavalid & empty;
  assign g_lost = (bus.g_read | bus.g_write)
                & ~(sel_vld & (sel == PORT_GAME));

  assign bus.m_address    = ADDR_W'(cmd.address);
  assign bus.m_read       = m_rd;
  assign bus.m_write      = m_wr;
  assign bus.m_writedata  = DATA_W'(cmd.writedata);
  assign bus.m_byteenable = cmd.byteenable;

  assign bus.v_waitrequest =
    ~(accept & (sel == PORT_VIDEO));
  assign bus.g_waitrequest =
    ~(accept & (sel == PORT_GAME));

  assign bus.v_readdatavalid = v_rdv_q;
  assign bus.g_readdatavalid = g_rdv_q;
  assign bus.rdata           = rdata_q;
  assign bus.outstanding     = count;
  assign bus.err_stray_rdv   = err_q;

  arb_tag_fifo #(
    .DEPTH (MAX_OUT),
    .CNT_W (CNT_W)
  ) u_tags (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .din   (sel == PORT_GAME),
    .dout  (tag_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_q     <= 1'b0;
      grant_q    <= PORT_VIDEO;
      starve_cnt <= '0;
      v_rdv_q    <= 1'b0;
      g_rdv_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (stall) begin
        hold_q  <= 1'b1;
        grant_q <= sel;
      end else if (accept) begin
        hold_q  <= 1'b0;
      end
      if (accept & (sel == PORT_GAME))
        starve_cnt <= '0;
      else if (g_lost &
               (starve_cnt != ST_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
      v_rdv_q <= pop & ~tag_dout;
      g_rdv_q <= pop & tag_dout;
      if (pop)
        rdata_q <= bus.m_readdata;
      if (stray)
        err_q <= 1'b1;
    end
  end

endmodule
